// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder and related store logic.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package data_mem_responder_pkg;

  // Access size as issued by the core's control unit.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_size_t;

  // Responder control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rsp_state_t;

  // Byte-lane mask for an access of the given size at the given byte offset.
  // Misaligned combinations produce a mask with lanes shifted out; callers
  // must gate writes with the misalignment flag.
  function automatic logic [3:0] size_byte_mask(mem_access_size_t size, logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      MEM_BYTE: mask = 4'b0001 << offset;
      MEM_HALF: mask = 4'b0011 << offset;
      default:  mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane alignment for a 32-bit word memory port.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   size, offset  : access size and addr[1:0]
//   wdata         : right-justified store data
//   rword         : full RAM word being read
//   byte_en       : per-byte write enable mask
//   wdata_rep     : store data replicated onto every lane
//   rdata         : selected lane shifted down, zero-extended to 32 bits
//   misaligned    : half on odd address or word not on a 4-byte boundary
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  mem_access_size_t size,
  input  logic [1:0]       offset,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rword,
  output logic [3:0]       byte_en,
  output logic [31:0]      wdata_rep,
  output logic [31:0]      rdata,
  output logic             misaligned
);

  logic [31:0] rword_shifted;

  assign byte_en       = size_byte_mask(size, offset);
  assign rword_shifted = rword >> {offset, 3'b000};

  always_comb begin
    wdata_rep  = wdata;
    rdata      = rword_shifted;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {24'h0, rword_shifted[7:0]};
      end
      MEM_HALF: begin
        wdata_rep  = {2{wdata[15:0]}};
        rdata      = {16'h0, rword_shifted[15:0]};
        misaligned = offset[0];
      end
      default: begin
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder backed by an inferred word RAM.
// Latency: LATENCY cycles from request acceptance to rsp_valid_o.
// Backpressure: req_ready_o low while busy; response held until rsp_ready_i.
//
// Ports:
//   clk_i, reset_i            : clock, synchronous active-high reset
//   req_valid_i/req_ready_o   : request handshake
//   req_we_i, req_addr_i,
//   req_size_i, req_wdata_i   : request fields (write data right-justified)
//   rsp_valid_o/rsp_ready_i   : response handshake
//   rsp_rdata_o, rsp_error_o  : zero-extended read data, error flag
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [31:0]      req_addr_i,
  input  mem_access_size_t req_size_i,
  input  logic [31:0]      req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_error_o
);

  localparam int          IDX_W    = $clog2(DEPTH);
  // Span in bytes, one bit wider so a 4 GiB window cannot overflow.
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam int          CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  rsp_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [31:0]      offset;
  logic             out_of_range;
  logic [IDX_W-1:0] ram_idx;
  logic             accept;
  logic             req_err;
  logic             ram_we;

  logic [3:0]       byte_en;
  logic [31:0]      wdata_rep;
  logic [31:0]      lane_rdata;
  logic             misaligned;
  logic [31:0]      rword;

  logic [31:0]      mem [DEPTH];

  // Offset is unsigned 32-bit; addresses below the base are caught explicitly
  // rather than relying on wrap-around into a huge offset.
  assign offset       = req_addr_i - BASE_ADDR;
  assign out_of_range = (req_addr_i < BASE_ADDR) || ({1'b0, offset} >= SPAN);
  assign ram_idx      = offset[IDX_W+1:2];

  assign req_ready_o  = (state_q == ST_IDLE);
  assign accept       = req_valid_i && req_ready_o;
  assign req_err      = misaligned || out_of_range;
  // Reset in the acceptance cycle wins, so the write is suppressed.
  assign ram_we       = accept && req_we_i && !req_err && !reset_i;

  assign rword        = mem[ram_idx];

  mem_lane_align u_lane_align (
    .size       (req_size_i),
    .offset     (req_addr_i[1:0]),
    .wdata      (req_wdata_i),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_rep  (wdata_rep),
    .rdata      (lane_rdata),
    .misaligned (misaligned)
  );

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[ram_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Response payload is captured once at acceptance and then held
      // untouched through WAIT and any RESP stall.
      if (accept) begin
        err_q   <= req_err;
        rdata_q <= (req_we_i || req_err) ? 32'h0 : lane_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst1, rst3, v1, v3, we, rsp_rdy;
  logic [31:0]      addr, wdata;
  mem_access_size_t size;
  logic             rdy1, vld1, err1, rdy3, vld3, err3;
  logic [31:0]      rd1, rd3;

  // Instance "1": LATENCY=1, base 0, 1024 words.
  data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
    .clk_i(clk), .reset_i(rst1), .req_valid_i(v1), .req_ready_o(rdy1),
    .req_we_i(we), .req_addr_i(addr), .req_size_i(size), .req_wdata_i(wdata),
    .rsp_valid_o(vld1), .rsp_ready_i(rsp_rdy), .rsp_rdata_o(rd1), .rsp_error_o(err1)
  );

  // Instance "3": LATENCY=3, base 0x2000, 256 words (0x2000..0x23FF).
  data_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h2000), .LATENCY(3)) dut3 (
    .clk_i(clk), .reset_i(rst3), .req_valid_i(v3), .req_ready_o(rdy3),
    .req_we_i(we), .req_addr_i(addr), .req_size_i(size), .req_wdata_i(wdata),
    .rsp_valid_o(vld3), .rsp_ready_i(rsp_rdy), .rsp_rdata_o(rd3), .rsp_error_o(err3)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit               sel;   // 0 -> LATENCY=1 instance, 1 -> LATENCY=3 instance
    logic             we;
    logic [31:0]      addr;
    mem_access_size_t size;
    logic [31:0]      wdata;
    logic [31:0]      exp_rdata;
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic cur_ready(input bit sel);
    return sel ? rdy3 : rdy1;
  endfunction
  function automatic logic cur_valid(input bit sel);
    return sel ? vld3 : vld1;
  endfunction
  function automatic logic [31:0] cur_rdata(input bit sel);
    return sel ? rd3 : rd1;
  endfunction
  function automatic logic cur_err(input bit sel);
    return sel ? err3 : err1;
  endfunction

  // Drive one request, wait for acceptance, measure latency, compare the
  // response against the scoreboard, and confirm the port reopens.
  task automatic run_req(input bit sel, input logic w, input logic [31:0] a,
                         input mem_access_size_t s, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input string name);
    int   n;
    bit   ok;
    int   lat;
    rsp_t e;
    lat = sel ? 3 : 1;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    we = w; addr = a; size = s; wdata = d;
    if (sel) v3 = 1'b1; else v1 = 1'b1;
    n = 0;
    while (!cur_ready(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " accept"}, 32'(cur_ready(sel)), 32'd1);
    @(posedge clk);
    #1;
    v1 = 1'b0; v3 = 1'b0;
    ok = 0; n = 0;
    for (int i = 1; i <= 20 && !ok; i++) begin
      @(negedge clk);
      if (cur_valid(sel)) begin
        ok = 1;
        n = i;
      end
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    e = sb.pop_front();
    chk({name, " rdata"}, cur_rdata(sel), e.rdata);
    chk({name, " err"}, 32'(cur_err(sel)), 32'(e.err));
    chk({name, " busy"}, 32'(cur_ready(sel)), 32'd0);
    @(negedge clk);
    chk({name, " reopen"}, 32'(cur_ready(sel)), 32'd1);
    chk({name, " vld_drop"}, 32'(cur_valid(sel)), 32'd0);
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; v1 = 1'b0; v3 = 1'b0; we = 1'b0;
    rsp_rdy = 1'b1; addr = '0; wdata = '0; size = MEM_WORD;
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("rst rdy1", 32'(rdy1), 32'd1);
    chk("rst vld1", 32'(vld1), 32'd0);
    chk("rst rd1", rd1, 32'h0);
    chk("rst err1", 32'(err1), 32'd0);
    chk("rst rdy3", 32'(rdy3), 32'd1);
    chk("rst vld3", 32'(vld3), 32'd0);
    chk("rst rd3", rd3, 32'h0);
    chk("rst err3", 32'(err3), 32'd0);

    //              sel we  addr             size      wdata          exp_rdata      err
    vecs.push_back('{0, 1, 32'h0000_0010, MEM_WORD, 32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{0, 0, 32'h0000_0010, MEM_WORD, 32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{0, 1, 32'h0000_0013, MEM_BYTE, 32'h0000_00A5, 32'h0,       0});
    vecs.push_back('{0, 0, 32'h0000_0010, MEM_WORD, 32'h0,        32'hA5ADBEEF, 0});
    vecs.push_back('{0, 0, 32'h0000_0012, MEM_BYTE, 32'h0,        32'h0000_00AD, 0});
    vecs.push_back('{0, 0, 32'h0000_0012, MEM_HALF, 32'h0,        32'h0000_A5AD, 0});
    vecs.push_back('{0, 1, 32'h0000_0011, MEM_HALF, 32'h0000_1234, 32'h0,       1});
    vecs.push_back('{0, 0, 32'h0000_0006, MEM_WORD, 32'h0,        32'h0,        1});
    vecs.push_back('{0, 0, 32'h0000_0010, MEM_WORD, 32'h0,        32'hA5ADBEEF, 0});
    vecs.push_back('{0, 0, 32'h0000_1000, MEM_WORD, 32'h0,        32'h0,        1});
    vecs.push_back('{0, 1, 32'h0000_1000, MEM_WORD, 32'h1234_5678, 32'h0,       1});
    vecs.push_back('{0, 1, 32'h0000_0011, MEM_BYTE, 32'hFFFF_FF77, 32'h0,       0});
    vecs.push_back('{0, 0, 32'h0000_0010, MEM_WORD, 32'h0,        32'hA5AD77EF, 0});
    vecs.push_back('{0, 1, 32'h0000_0010, MEM_HALF, 32'hFFFF_5A5A, 32'h0,       0});
    vecs.push_back('{0, 0, 32'h0000_0010, MEM_WORD, 32'h0,        32'hA5AD5A5A, 0});
    vecs.push_back('{0, 0, 32'h0000_0010, MEM_HALF, 32'h0,        32'h0000_5A5A, 0});
    vecs.push_back('{0, 0, 32'h0000_0013, MEM_BYTE, 32'h0,        32'h0000_00A5, 0});
    vecs.push_back('{0, 0, 32'h0000_0013, MEM_HALF, 32'h0,        32'h0,        1});
    vecs.push_back('{0, 1, 32'h0000_0FFC, MEM_WORD, 32'h0BAD_F00D, 32'h0,       0});
    vecs.push_back('{0, 0, 32'h0000_0FFC, MEM_WORD, 32'h0,        32'h0BADF00D, 0});
    vecs.push_back('{0, 0, 32'hFFFF_FFFC, MEM_WORD, 32'h0,        32'h0,        1});
    vecs.push_back('{0, 0, 32'h0000_1003, MEM_BYTE, 32'h0,        32'h0,        1});
    vecs.push_back('{1, 1, 32'h0000_2000, MEM_WORD, 32'h1122_3344, 32'h0,       0});
    vecs.push_back('{1, 0, 32'h0000_2002, MEM_HALF, 32'h0,        32'h0000_1122, 0});
    vecs.push_back('{1, 0, 32'h0000_2001, MEM_BYTE, 32'h0,        32'h0000_0033, 0});
    vecs.push_back('{1, 0, 32'h0000_1FFC, MEM_WORD, 32'h0,        32'h0,        1});
    vecs.push_back('{1, 0, 32'h0000_2400, MEM_WORD, 32'h0,        32'h0,        1});
    vecs.push_back('{1, 1, 32'h0000_23FC, MEM_WORD, 32'h89AB_CDEF, 32'h0,       0});
    vecs.push_back('{1, 0, 32'h0000_23FC, MEM_WORD, 32'h0,        32'h89ABCDEF, 0});

    foreach (vecs[i]) begin
      run_req(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("v%0d", i));
    end

    // Stall: LATENCY=3 read with rsp_ready low for 4 cycles after valid rises.
    begin
      int  n;
      bit  ok;
      rsp_t e;
      sb.push_back('{rdata: 32'h1122_3344, err: 1'b0});
      @(negedge clk);
      rsp_rdy = 1'b0;
      we = 1'b0; addr = 32'h2000; size = MEM_WORD; wdata = '0; v3 = 1'b1;
      chk("stall accept", 32'(rdy3), 32'd1);
      @(posedge clk);
      #1 v3 = 1'b0;
      ok = 0; n = 0;
      for (int i = 1; i <= 20 && !ok; i++) begin
        @(negedge clk);
        if (vld3) begin ok = 1; n = i; end
      end
      chk("stall latency", 32'(n), 32'd3);
      e = sb.pop_front();
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        chk($sformatf("stall vld%0d", k), 32'(vld3), 32'd1);
        chk($sformatf("stall data%0d", k), rd3, e.rdata);
        chk($sformatf("stall rdy%0d", k), 32'(rdy3), 32'd0);
      end
      rsp_rdy = 1'b1;
      @(negedge clk);
      chk("stall reopen", 32'(rdy3), 32'd1);
      chk("stall vld_drop", 32'(vld3), 32'd0);
    end

    // Reset pulsed while in WAIT drops the response but keeps the write.
    @(negedge clk);
    we = 1'b1; addr = 32'h2008; size = MEM_WORD; wdata = 32'hCAFE_F00D; v3 = 1'b1;
    chk("rstwait accept", 32'(rdy3), 32'd1);
    @(posedge clk);
    #1 v3 = 1'b0; we = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("rstwait rdy", 32'(rdy3), 32'd1);
    chk("rstwait vld", 32'(vld3), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstwait novld%0d", k), 32'(vld3), 32'd0);
    end
    run_req(1, 0, 32'h2008, MEM_WORD, 32'h0, 32'hCAFE_F00D, 0, "rstwait readback");

    // Reset coinciding with acceptance suppresses the write.
    run_req(0, 1, 32'h30, MEM_WORD, 32'h1111_1111, 32'h0, 0, "coll seed");
    @(negedge clk);
    we = 1'b1; addr = 32'h30; size = MEM_WORD; wdata = 32'h2222_2222; v1 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; rst1 = 1'b0; we = 1'b0;
    chk("coll vld", 32'(vld1), 32'd0);
    chk("coll rdy", 32'(rdy1), 32'd1);
    run_req(0, 0, 32'h30, MEM_WORD, 32'h0, 32'h1111_1111, 0, "coll readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data/instruction memory port. It accepts one request at a time (read or write, byte/half/word size) over a valid/ready handshake. It serves the request from an internal word-organised RAM after a configurable latency and returns aligned, zero-extended read data plus an error flag. It sits between the multicycle core datapath and storage, answering the accesses sequenced by the core's control unit.

## Interface
Parameters:
- DEPTH, 1024: RAM size in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000: byte address of word 0 (DEPTH*4-aligned).
- LATENCY, 1: cycles from request acceptance to rsp_valid_o (≥1).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  32  byte address.
- req_size_i  in  mem_access_size_t  BYTE/HALF/WORD.
- req_wdata_i  in  32  write data, right-justified (bits [7:0] for byte, [15:0] for half).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  core consumes response.
- rsp_rdata_o  out  32  read data, right-justified, zero-extended; 0 for writes and errors.
- rsp_error_o  out  1  access was misaligned or out of range.

## Operation
- States: IDLE, WAIT, RESP.
- In IDLE, req_ready_o = 1. Acceptance is req_valid_i && req_ready_o.
- On acceptance, the request is checked.
  - Misaligned if HALF && addr[0], or WORD && addr[1:0] != 0.
  - Out of range if addr outside [BASE_ADDR, BASE_ADDR + 4*DEPTH).
  - Either condition sets the error flag. An errored write does not modify the RAM.
- Valid write: the byte-enable mask comes from size and addr[1:0] (byte: 1 << addr[1:0]; half: 2'b11 << addr[1:0]; word: 4'hF). Write data is replicated onto all lanes and masked. The RAM updates at the acceptance edge.
- Valid read: the word at index (addr - BASE_ADDR) >> 2 is read at acceptance. The selected lane is shifted down by 8*addr[1:0], masked to size, and registered.
- After acceptance:
  - LATENCY == 1: go to RESP.
  - LATENCY > 1: go to WAIT, with the down-counter set to LATENCY-2. WAIT goes to RESP when the counter is 0; otherwise it decrements.
- RESP: rsp_valid_o = 1, and rsp_rdata_o/rsp_error_o are held stable until rsp_ready_i. On the handshake edge, go to IDLE.
- req_ready_o = 0 in WAIT and RESP. Requests presented then are ignored; the initiator holds them.
- Sign extension is not done here; the core applies it on the regfile side.

## Timing
- Accept in cycle T, so rsp_valid_o rises in cycle T+LATENCY.
- With rsp_ready_i high, the next acceptance is possible at T+LATENCY+1. Peak throughput is one access per LATENCY+1 cycles.
- Read-after-write: a read accepted after a write returns the written data. The write commits at its acceptance edge.
- Reset values: state IDLE, rsp_valid_o 0, rsp_rdata_o 0, rsp_error_o 0, counter 0. req_ready_o is 1 in the first cycle after reset_i deasserts. RAM contents are not reset.
- Reset mid-operation:
  - A pending response is dropped.
  - A write already accepted remains committed.
  - Reset asserted in the same cycle as acceptance takes priority: no RAM write.
- Widths:
  - Address offset arithmetic is 32-bit unsigned; comparison uses no wrap-around.
  - RAM index is $clog2(DEPTH) bits.

## Structure
- mem_access_size_t is reused from the shared definitions package.
- Add to the package: the responder state enum (IDLE/WAIT/RESP), and a function or constants for the size-to-byte-mask mapping, shared with any future store logic.
- Sub-module mem_lane_align (combinational): size and addr[1:0] in; byte mask, write-lane replication, read-lane extraction and misalignment flag out.
- The RAM array is inferred inside data_mem_responder with per-byte write enables.

## Test plan
- Word write 32'hDEADBEEF to 0x10, then word read of 0x10 (LATENCY=1) -> rsp_rdata_o = 32'hDEADBEEF, rsp_error_o 0, rsp_valid_o exactly 1 cycle after each acceptance.
- Byte write 8'hA5 to 0x13 over that word, then read word 0x10 -> 32'hA5ADBEEF. Byte read 0x12 -> 32'h000000AD. Half read 0x12 -> 32'h0000A5AD.
- Half write to 0x11 and word read of 0x06 -> rsp_error_o 1, rsp_rdata_o 0, and a following read of word 0x10 shows memory unchanged.
- Out-of-range read at BASE_ADDR + 4*DEPTH -> rsp_error_o 1, with normal handshake timing.
- LATENCY=3, rsp_ready_i held low for 4 cycles after rsp_valid_o rises:
  - rsp_valid_o rises at T+3.
  - Data stays stable through the stall.
  - req_ready_o stays 0 until the cycle after the handshake.
- reset_i pulsed one cycle while in WAIT:
  - rsp_valid_o never asserts for that request.
  - req_ready_o = 1 the next cycle.
  - The write accepted before reset reads back correctly.
